// File: rtl/snake_engine.sv
// snake_engine: game-logic stage that owns one snake body (ring buffer of
// cell coordinates) and advances it one cell per game tick, updating the
// shared map through a read/write port.
//
// Build option: define SNAKE_WRAP_EN to wrap the head around the map edges;
// when undefined, crossing an edge kills the snake without touching the map.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   start                 one-cycle pulse, (re)initialises the snake
//   dir_in, dir_valid     direction request (0=UP 1=RIGHT 2=DOWN 3=LEFT)
//   rd_x, rd_y, rd_data   map read port (data valid one cycle after address)
//   wr_en, wr_x, wr_y,
//   wr_data               map write port (one-cycle strobe per write)
//   alive, busy           status: snake running / FSM between moves
//   score, length         food eaten (saturating), current body length
//   head_x, head_y        current head cell
module snake_engine #(
  parameter int unsigned MAP_W     = 32,
  parameter int unsigned MAP_H     = 24,
  parameter int unsigned MAX_LEN   = 64,
  parameter int unsigned START_LEN = 3,
  parameter int unsigned START_X   = 8,
  parameter int unsigned START_Y   = 12,
  parameter int unsigned TICK_DIV  = 7500000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [1:0]                    dir_in,
  input  logic                          dir_valid,
  output logic [$clog2(MAP_W)-1:0]      rd_x,
  output logic [$clog2(MAP_H)-1:0]      rd_y,
  input  logic [1:0]                    rd_data,
  output logic                          wr_en,
  output logic [$clog2(MAP_W)-1:0]      wr_x,
  output logic [$clog2(MAP_H)-1:0]      wr_y,
  output logic [1:0]                    wr_data,
  output logic                          alive,
  output logic                          busy,
  output logic [7:0]                    score,
  output logic [$clog2(MAX_LEN+1)-1:0]  length,
  output logic [$clog2(MAP_W)-1:0]      head_x,
  output logic [$clog2(MAP_H)-1:0]      head_y
);

  localparam int unsigned XW = $clog2(MAP_W);
  localparam int unsigned YW = $clog2(MAP_H);
  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] CELL_EMPTY = 2'd0;
  localparam logic [1:0] CELL_SNAKE = 2'd1;
  localparam logic [1:0] CELL_FOOD  = 2'd2;
  localparam logic [1:0] CELL_WALL  = 2'd3;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [2:0] {
    S_DEAD,
    S_INIT,
    S_WAIT,
    S_READ,
    S_CHECK,
    S_WRITE_HEAD,
    S_CLEAR_TAIL
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [IW-1:0]   init_cnt_q, init_cnt_d;
  logic [1:0]      dir_q, dir_d;
  logic [1:0]      pend_q, pend_d;
  logic [IW-1:0]   head_idx_q, head_idx_d;
  logic [IW-1:0]   tail_idx_q, tail_idx_d;
  logic [XW-1:0]   head_x_q, head_x_d;
  logic [YW-1:0]   head_y_q, head_y_d;
  logic [XW-1:0]   next_x_q, next_x_d;
  logic [YW-1:0]   next_y_q, next_y_d;
  logic            oob_q, oob_d;
  logic            grow_q, grow_d;
  logic [XW-1:0]   tail_x_q, tail_x_d;
  logic [YW-1:0]   tail_y_q, tail_y_d;
  logic [LW-1:0]   length_q, length_d;
  logic [7:0]      score_q, score_d;
  logic            alive_q, alive_d;
  logic            busy_q, busy_d;
  logic            wr_en_q, wr_en_d;
  logic [XW-1:0]   wr_x_q, wr_x_d;
  logic [YW-1:0]   wr_y_q, wr_y_d;
  logic [1:0]      wr_data_q, wr_data_d;
  logic [XW-1:0]   rd_x_q, rd_x_d;
  logic [YW-1:0]   rd_y_q, rd_y_d;

  // Body storage; contents are only meaningful between head and tail indices.
  logic [XW-1:0]   ring_x_q [MAX_LEN];
  logic [YW-1:0]   ring_y_q [MAX_LEN];
  logic            ring_we;
  logic [IW-1:0]   ring_idx;
  logic [XW-1:0]   ring_wx;
  logic [YW-1:0]   ring_wy;

  logic [XW-1:0]   step_x;
  logic [YW-1:0]   step_y;
  logic            step_oob;
  logic [IW-1:0]   head_prev;
  logic [IW-1:0]   tail_prev;
  logic            tail_hit;

  // Candidate head one cell along the pending direction (committed at the tick).
  always_comb begin
    step_x   = head_x_q;
    step_y   = head_y_q;
    step_oob = 1'b0;
    case (pend_q)
      DIR_UP: begin
        if (head_y_q == '0) begin
`ifdef SNAKE_WRAP_EN
          step_y = YW'(MAP_H - 1);
`else
          step_oob = 1'b1;
`endif
        end else begin
          step_y = head_y_q - YW'(1);
        end
      end
      DIR_RIGHT: begin
        if (head_x_q == XW'(MAP_W - 1)) begin
`ifdef SNAKE_WRAP_EN
          step_x = '0;
`else
          step_oob = 1'b1;
`endif
        end else begin
          step_x = head_x_q + XW'(1);
        end
      end
      DIR_DOWN: begin
        if (head_y_q == YW'(MAP_H - 1)) begin
`ifdef SNAKE_WRAP_EN
          step_y = '0;
`else
          step_oob = 1'b1;
`endif
        end else begin
          step_y = head_y_q + YW'(1);
        end
      end
      default: begin
        if (head_x_q == '0) begin
`ifdef SNAKE_WRAP_EN
          step_x = XW'(MAP_W - 1);
`else
          step_oob = 1'b1;
`endif
        end else begin
          step_x = head_x_q - XW'(1);
        end
      end
    endcase
  end

  // The ring grows towards lower indices: head and tail both step down modulo MAX_LEN.
  assign head_prev = (head_idx_q == '0) ? IW'(MAX_LEN - 1) : head_idx_q - IW'(1);
  assign tail_prev = (tail_idx_q == '0) ? IW'(MAX_LEN - 1) : tail_idx_q - IW'(1);
  assign tail_hit  = (next_x_q == tail_x_q) && (next_y_q == tail_y_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    init_cnt_d = init_cnt_q;
    dir_d      = dir_q;
    pend_d     = pend_q;
    head_idx_d = head_idx_q;
    tail_idx_d = tail_idx_q;
    head_x_d   = head_x_q;
    head_y_d   = head_y_q;
    next_x_d   = next_x_q;
    next_y_d   = next_y_q;
    oob_d      = oob_q;
    grow_d     = grow_q;
    tail_x_d   = tail_x_q;
    tail_y_d   = tail_y_q;
    length_d   = length_q;
    score_d    = score_q;
    alive_d    = alive_q;
    wr_en_d    = 1'b0;
    wr_x_d     = wr_x_q;
    wr_y_d     = wr_y_q;
    wr_data_d  = wr_data_q;
    rd_x_d     = rd_x_q;
    rd_y_d     = rd_y_q;
    ring_we    = 1'b0;
    ring_idx   = head_idx_q;
    ring_wx    = next_x_q;
    ring_wy    = next_y_q;

    // A 180-degree reversal of the last committed move is dropped.
    if (state_q != S_DEAD && state_q != S_INIT && dir_valid &&
        dir_in != (dir_q ^ 2'd2)) begin
      pend_d = dir_in;
    end

    case (state_q)
      S_DEAD: begin
      end

      S_INIT: begin
        wr_en_d   = 1'b1;
        wr_x_d    = XW'(START_X) - XW'(init_cnt_q);
        wr_y_d    = YW'(START_Y);
        wr_data_d = CELL_SNAKE;
        ring_we   = 1'b1;
        ring_idx  = init_cnt_q;
        ring_wx   = XW'(START_X) - XW'(init_cnt_q);
        ring_wy   = YW'(START_Y);
        if (init_cnt_q == IW'(START_LEN - 1)) begin
          alive_d = 1'b1;
          state_d = S_WAIT;
        end else begin
          init_cnt_d = init_cnt_q + IW'(1);
        end
      end

      S_WAIT: begin
        if (tick_q == TW'(TICK_DIV - 1)) begin
          // Commit the direction and present the read address for READ.
          tick_d   = '0;
          dir_d    = pend_q;
          next_x_d = step_x;
          next_y_d = step_y;
          oob_d    = step_oob;
          if (!step_oob) begin
            rd_x_d = step_x;
            rd_y_d = step_y;
          end
          state_d = S_READ;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end

      S_READ: begin
        // Snapshot the tail: the head push may overwrite its slot at MAX_LEN.
        tail_x_d = ring_x_q[tail_idx_q];
        tail_y_d = ring_y_q[tail_idx_q];
        grow_d   = 1'b0;
        if (oob_q) begin
          alive_d = 1'b0;
          state_d = S_DEAD;
        end else begin
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        case (rd_data)
          CELL_SNAKE, CELL_WALL: begin
            // The tail cell vacates this move, so stepping onto it is legal.
            if (tail_hit && !grow_q) begin
              state_d = S_WRITE_HEAD;
            end else begin
              alive_d = 1'b0;
              state_d = S_DEAD;
            end
          end
          CELL_FOOD: begin
            grow_d  = 1'b1;
            state_d = S_WRITE_HEAD;
          end
          default: begin
            state_d = S_WRITE_HEAD;
          end
        endcase
      end

      S_WRITE_HEAD: begin
        wr_en_d    = 1'b1;
        wr_x_d     = next_x_q;
        wr_y_d     = next_y_q;
        wr_data_d  = CELL_SNAKE;
        ring_we    = 1'b1;
        ring_idx   = head_prev;
        head_idx_d = head_prev;
        head_x_d   = next_x_q;
        head_y_d   = next_y_q;
        if (grow_q && score_q != 8'hFF) begin
          score_d = score_q + 8'd1;
        end
        if (grow_q && length_q < LW'(MAX_LEN)) begin
          length_d = length_q + LW'(1);
          state_d  = S_WAIT;
        end else if (tail_hit) begin
          // Head took over the old tail cell: nothing to erase.
          tail_idx_d = tail_prev;
          state_d    = S_WAIT;
        end else begin
          state_d = S_CLEAR_TAIL;
        end
      end

      S_CLEAR_TAIL: begin
        wr_en_d    = 1'b1;
        wr_x_d     = tail_x_q;
        wr_y_d     = tail_y_q;
        wr_data_d  = CELL_EMPTY;
        tail_idx_d = tail_prev;
        state_d    = S_WAIT;
      end

      default: begin
        state_d = S_DEAD;
      end
    endcase

    // start wins from any state.
    if (start) begin
      state_d    = S_INIT;
      init_cnt_d = '0;
      head_idx_d = '0;
      tail_idx_d = IW'(START_LEN - 1);
      head_x_d   = XW'(START_X);
      head_y_d   = YW'(START_Y);
      length_d   = LW'(START_LEN);
      score_d    = '0;
      alive_d    = 1'b0;
      dir_d      = DIR_RIGHT;
      pend_d     = DIR_RIGHT;
      tick_d     = '0;
      wr_en_d    = 1'b0;
      ring_we    = 1'b0;
    end

    busy_d = !(state_d == S_WAIT || state_d == S_DEAD);
  end

  // State and control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_DEAD;
      tick_q     <= '0;
      init_cnt_q <= '0;
      dir_q      <= DIR_RIGHT;
      pend_q     <= DIR_RIGHT;
      head_idx_q <= '0;
      tail_idx_q <= '0;
      head_x_q   <= XW'(START_X);
      head_y_q   <= YW'(START_Y);
      next_x_q   <= '0;
      next_y_q   <= '0;
      oob_q      <= 1'b0;
      grow_q     <= 1'b0;
      tail_x_q   <= '0;
      tail_y_q   <= '0;
      length_q   <= '0;
      score_q    <= '0;
      alive_q    <= 1'b0;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
      wr_data_q  <= CELL_EMPTY;
      rd_x_q     <= '0;
      rd_y_q     <= '0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      init_cnt_q <= init_cnt_d;
      dir_q      <= dir_d;
      pend_q     <= pend_d;
      head_idx_q <= head_idx_d;
      tail_idx_q <= tail_idx_d;
      head_x_q   <= head_x_d;
      head_y_q   <= head_y_d;
      next_x_q   <= next_x_d;
      next_y_q   <= next_y_d;
      oob_q      <= oob_d;
      grow_q     <= grow_d;
      tail_x_q   <= tail_x_d;
      tail_y_q   <= tail_y_d;
      length_q   <= length_d;
      score_q    <= score_d;
      alive_q    <= alive_d;
      busy_q     <= busy_d;
      wr_en_q    <= wr_en_d;
      wr_x_q     <= wr_x_d;
      wr_y_q     <= wr_y_d;
      wr_data_q  <= wr_data_d;
      rd_x_q     <= rd_x_d;
      rd_y_q     <= rd_y_d;
    end
  end

  // Ring buffer storage, rewritten by INIT before use so it needs no reset.
  always_ff @(posedge clk) begin
    if (ring_we) begin
      ring_x_q[ring_idx] <= ring_wx;
      ring_y_q[ring_idx] <= ring_wy;
    end
  end

  assign rd_x    = rd_x_q;
  assign rd_y    = rd_y_q;
  assign wr_en   = wr_en_q;
  assign wr_x    = wr_x_q;
  assign wr_y    = wr_y_q;
  assign wr_data = wr_data_q;
  assign alive   = alive_q;
  assign busy    = busy_q;
  assign score   = score_q;
  assign length  = length_q;
  assign head_x  = head_x_q;
  assign head_y  = head_y_q;

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: expected map writes are queued as each
// step is set up and compared as the DUT issues them.
module tb_snake_engine;

  localparam int unsigned TICK = 8;
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] SNAKE = 2'd1;
  localparam logic [1:0] FOOD  = 2'd2;
  localparam logic [1:0] WALL  = 2'd3;
  localparam logic [1:0] UP    = 2'd0;
  localparam logic [1:0] LEFT  = 2'd3;

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
    logic [1:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] dir_in = 2'd0;
  logic       dir_valid = 1'b0;
  logic [4:0] rd_x;
  logic [4:0] rd_y;
  logic [1:0] rd_data = 2'd0;
  logic [1:0] rd_force = 2'd0;
  logic       wr_en;
  logic [4:0] wr_x;
  logic [4:0] wr_y;
  logic [1:0] wr_data;
  logic       alive;
  logic       busy;
  logic [7:0] score;
  logic [6:0] length;
  logic [4:0] head_x;
  logic [4:0] head_y;

  int  n_vec = 0;
  int  n_err = 0;
  wr_t exp_q[$];
  wr_t exp_w;

  snake_engine #(.TICK_DIV(TICK)) dut (
    .clk(clk), .rst(rst), .start(start), .dir_in(dir_in), .dir_valid(dir_valid),
    .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .alive(alive), .busy(busy), .score(score), .length(length),
    .head_x(head_x), .head_y(head_y)
  );

  always #5 clk = ~clk;

  // Map read model: the cell value the bench wants seen, one cycle after address.
  always @(posedge clk) rd_data <= rd_force;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int x, input int y, input logic [1:0] d);
    exp_q.push_back('{x: 5'(x), y: 5'(y), d: d});
  endtask

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'({wr_x, wr_y, wr_data}), 32'hFFFF_FFFF);
      end else begin
        exp_w = exp_q.pop_front();
        check("write", 32'({wr_x, wr_y, wr_data}), 32'(exp_w));
      end
    end
  end

  task automatic wait_move(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_dead(input string tag);
    int n;
    n = 0;
    while (alive !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_alive"}, 32'(alive), 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic dir_req(input logic [1:0] d);
    dir_in    = d;
    dir_valid = 1'b1;
    @(negedge clk);
    dir_valid = 1'b0;
  endtask

  task automatic push_init();
    push(8, 12, SNAKE);
    push(7, 12, SNAKE);
    push(6, 12, SNAKE);
  endtask

  task automatic check_head(input string tag, input int x, input int y);
    check({tag, "_head_x"}, 32'(head_x), 32'(x));
    check({tag, "_head_y"}, 32'(head_y), 32'(y));
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_alive", 32'(alive), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_length", 32'(length), 32'd0);
    check_head("rst", 8, 12);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("dead_holds", 32'(busy), 32'd0);

    // Start: three body cells written, head first.
    push_init();
    pulse_start();
    wait_move("init");
    check("init_alive", 32'(alive), 32'd1);
    check("init_length", 32'(length), 32'd3);
    check("init_score", 32'(score), 32'd0);
    check_head("init", 8, 12);

    // Free moves to the right.
    push(9, 12, SNAKE);  push(6, 12, EMPTY); wait_move("mv1"); check_head("mv1", 9, 12);
    push(10, 12, SNAKE); push(7, 12, EMPTY); wait_move("mv2"); check_head("mv2", 10, 12);

    // Reverse request is dropped.
    push(11, 12, SNAKE); push(8, 12, EMPTY);
    dir_req(LEFT);
    wait_move("rev"); check_head("rev", 11, 12);

    // UP then LEFT in one tick: LEFT still reverses the committed RIGHT, UP commits.
    push(11, 11, SNAKE); push(9, 12, EMPTY);
    dir_req(UP);
    dir_req(LEFT);
    wait_move("up"); check_head("up", 11, 11);

    // LEFT is legal once UP is committed.
    push(10, 11, SNAKE); push(10, 12, EMPTY);
    dir_req(LEFT);
    wait_move("left"); check_head("left", 10, 11);

    // Food: grow without erasing the tail.
    rd_force = FOOD;
    push(9, 11, SNAKE);
    wait_move("food");
    rd_force = EMPTY;
    check("food_length", 32'(length), 32'd4);
    check("food_score", 32'(score), 32'd1);
    check_head("food", 9, 11);

    // Wall: death, then silence on the write port.
    rd_force = WALL;
    wait_dead("wall");
    rd_force = EMPTY;
    repeat (40) @(negedge clk);
    check("wall_busy", 32'(busy), 32'd0);
    check("wall_wr_en", 32'(wr_en), 32'd0);
    check_head("wall", 9, 11);

    // Restart and run to the right edge.
    push_init();
    pulse_start();
    wait_move("init2");
    check("init2_score", 32'(score), 32'd0);
    check("init2_length", 32'(length), 32'd3);
    for (int i = 9; i <= 31; i++) begin
      push(i, 12, SNAKE);
      push(i - 3, 12, EMPTY);
      wait_move("run");
    end
    check_head("edge", 31, 12);
`ifdef SNAKE_WRAP_EN
    push(0, 12, SNAKE); push(29, 12, EMPTY);
    wait_move("wrap");
    check_head("wrap", 0, 12);
    check("wrap_alive", 32'(alive), 32'd1);
`else
    wait_dead("edge");
    check_head("edge_dead", 31, 12);
    repeat (20) @(negedge clk);
`endif

    // Reset asserted while WRITE_HEAD is the current state.
    push_init();
    pulse_start();
    wait_move("init3");
    n = 0;
    while (busy !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("move_start", 32'(busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_alive", 32'(alive), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_wr_en", 32'(wr_en), 32'd0);
    check("mid_length", 32'(length), 32'd0);
    check("mid_score", 32'(score), 32'd0);
    check_head("mid", 8, 12);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_wr_en", 32'(wr_en), 32'd0);

    push_init();
    pulse_start();
    wait_move("init4");
    check("init4_alive", 32'(alive), 32'd1);
    check("init4_length", 32'(length), 32'd3);
    check_head("init4", 8, 12);
    push(9, 12, SNAKE); push(6, 12, EMPTY);
    wait_move("post");
    check_head("post", 9, 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
